// File: rtl/mem_fu_responder_if.sv
// rtl/mem_fu_responder_if.sv - issue, retire-store and response signals of the memory functional unit
// Purpose : groups the reservation-station issue port, the two retire store ports and
//           the unit's response outputs into one bundle.
// Ports   : master = reservation station / retire logic side (drives issue and retire)
//           slave  = memory functional unit side (drives fu_ready, result_valid, fu_out, illegal_op)
interface mem_fu_responder_if;
    logic        issue_valid;
    logic [2:0]  fu_operation;
    logic [31:0] fu_inp1;
    logic [31:0] fu_inp2;
    logic [31:0] write_address1;
    logic [31:0] write_data1;
    logic        we1;
    logic [31:0] write_address2;
    logic [31:0] write_data2;
    logic        we2;
    logic        fu_ready;
    logic        result_valid;
    logic [31:0] fu_out;
    logic        illegal_op;

    modport master (
        output issue_valid, fu_operation, fu_inp1, fu_inp2,
        output write_address1, write_data1, we1,
        output write_address2, write_data2, we2,
        input  fu_ready, result_valid, fu_out, illegal_op
    );

    modport slave (
        input  issue_valid, fu_operation, fu_inp1, fu_inp2,
        input  write_address1, write_data1, we1,
        input  write_address2, write_data2, we2,
        output fu_ready, result_valid, fu_out, illegal_op
    );
endinterface

// File: rtl/mem_fu_responder.sv
// rtl/mem_fu_responder.sv - load/store functional unit with word-addressed data memory
// Purpose : accepts one load/store operation at a time, returns the load data (latency 2)
//           or the store effective address (latency 1); retire stores write the memory
//           in any state through two ports, port 2 (younger) winning on collisions.
// Ports   : clk   - single clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - slave side of mem_fu_responder_if (issue, retire writes, response)
module mem_fu_responder #(
    parameter int         MEM_WORDS = 256,
    parameter logic [2:0] OP_LOAD   = 3'd5,
    parameter logic [2:0] OP_STORE  = 3'd6
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_fu_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, LD_READ, RESP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fu_out_q, fu_out_d;
    logic               illegal_q, illegal_d;
    logic [IDX_W-1:0]   ld_idx_q, ld_idx_d;

    // Contents start at zero and deliberately survive reset.
    logic [31:0]        mem_q [MEM_WORDS] = '{default: '0};

    logic [31:0]        ea;
    logic [IDX_W-1:0]   ea_idx, wr_idx1, wr_idx2;
    logic [31:0]        rd_data;

    // Byte address -> word index: drop the two byte-offset bits, wrap to the depth.
    assign ea      = bus.fu_inp1 + bus.fu_inp2;
    assign ea_idx  = IDX_W'(ea >> 2);
    assign wr_idx1 = IDX_W'(bus.write_address1 >> 2);
    assign wr_idx2 = IDX_W'(bus.write_address2 >> 2);

    // Read sees retire writes landing on the same edge; port 2 is younger so it wins.
    always_comb begin
        rd_data = mem_q[ld_idx_q];
        if (bus.we2 && (wr_idx2 == ld_idx_q)) begin
            rd_data = bus.write_data2;
        end else if (bus.we1 && (wr_idx1 == ld_idx_q)) begin
            rd_data = bus.write_data1;
        end
    end

    always_comb begin
        state_d   = state_q;
        fu_out_d  = fu_out_q;
        illegal_d = illegal_q;
        ld_idx_d  = ld_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.issue_valid) begin
                    if (bus.fu_operation == OP_LOAD) begin
                        ld_idx_d = ea_idx;
                        state_d  = LD_READ;
                    end else if (bus.fu_operation == OP_STORE) begin
                        fu_out_d = ea;
                        state_d  = RESP;
                    end else begin
                        fu_out_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            LD_READ: begin
                fu_out_d = rd_data;
                state_d  = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fu_out_q  <= '0;
            illegal_q <= 1'b0;
            ld_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            fu_out_q  <= fu_out_d;
            illegal_q <= illegal_d;
            ld_idx_q  <= ld_idx_d;
        end
    end

    // Port 2 is written after port 1 so it holds the final value on a same-word collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus.we1) mem_q[wr_idx1] <= bus.write_data1;
            if (bus.we2) mem_q[wr_idx2] <= bus.write_data2;
        end
    end

    assign bus.fu_ready     = (state_q == IDLE);
    assign bus.result_valid = (state_q == RESP);
    assign bus.fu_out       = fu_out_q;
    assign bus.illegal_op   = illegal_q;
endmodule

// File: tb/tb_mem_fu_responder.sv
// tb/tb_mem_fu_responder.sv - self-checking bench for mem_fu_responder
module tb_mem_fu_responder;
    localparam logic [2:0] OP_LOAD  = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fu_responder_if bus ();

    mem_fu_responder #(.MEM_WORDS(256), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [256];
    bit          model_illegal = 1'b0;

    function automatic int unsigned widx(logic [31:0] a);
        return (a / 4) % 256;
    endfunction

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(bit w1, logic [31:0] a1, logic [31:0] d1,
                               bit w2, logic [31:0] a2, logic [31:0] d2);
        if (w1) model_mem[widx(a1)] = d1;
        if (w2) model_mem[widx(a2)] = d2;
    endtask

    task automatic retire(bit w1, logic [31:0] a1, logic [31:0] d1,
                          bit w2, logic [31:0] a2, logic [31:0] d2);
        bus.we1 = w1; bus.write_address1 = a1; bus.write_data1 = d1;
        bus.we2 = w2; bus.write_address2 = a2; bus.write_data2 = d2;
        tick();
        bus.we1 = 1'b0; bus.we2 = 1'b0;
        model_write(w1, a1, d1, w2, a2, d2);
    endtask

    // Issue one operation, keep issue_valid high while busy, optionally retire-write
    // through port 2 during the load's read cycle, and check the full response window.
    task automatic issue(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         bit fw, logic [31:0] fw_a, logic [31:0] fw_d);
        logic [31:0] ea;
        logic [31:0] exp;
        ea = a + b;
        bus.issue_valid = 1'b1; bus.fu_operation = op; bus.fu_inp1 = a; bus.fu_inp2 = b;
        chk1({tag, ".ready_before"}, bus.fu_ready, 1'b1);
        tick();
        bus.fu_inp1 = $urandom;
        bus.fu_inp2 = $urandom;
        if (op == OP_LOAD) begin
            chk1({tag, ".ready_ld"}, bus.fu_ready, 1'b0);
            chk1({tag, ".rv_ld"}, bus.result_valid, 1'b0);
            bus.we2 = fw; bus.write_address2 = fw_a; bus.write_data2 = fw_d;
            tick();
            bus.we2 = 1'b0;
            model_write(1'b0, 32'h0, 32'h0, fw, fw_a, fw_d);
            exp = model_mem[widx(ea)];
        end else if (op == OP_STORE) begin
            exp = ea;
        end else begin
            exp = 32'h0;
            model_illegal = 1'b1;
        end
        chk1({tag, ".rv"}, bus.result_valid, 1'b1);
        chk32({tag, ".out"}, bus.fu_out, exp);
        chk1({tag, ".ready_resp"}, bus.fu_ready, 1'b0);
        chk1({tag, ".illegal"}, bus.illegal_op, model_illegal);
        tick();
        bus.issue_valid = 1'b0;
        chk1({tag, ".rv_after"}, bus.result_valid, 1'b0);
        chk32({tag, ".out_hold"}, bus.fu_out, exp);
        chk1({tag, ".ready_after"}, bus.fu_ready, 1'b1);
        tick();
        chk1({tag, ".no_reissue"}, bus.result_valid, 1'b0);
        chk1({tag, ".ready_idle"}, bus.fu_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] a;
        logic [31:0] a1;
        logic [31:0] a2;
        int unsigned kind;
        logic [2:0] bad_ops [6];
        bad_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        bus.issue_valid = 1'b0; bus.fu_operation = 3'd0; bus.fu_inp1 = '0; bus.fu_inp2 = '0;
        bus.we1 = 1'b0; bus.write_address1 = '0; bus.write_data1 = '0;
        bus.we2 = 1'b0; bus.write_address2 = '0; bus.write_data2 = '0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk1("rst.ready", bus.fu_ready, 1'b1);
        chk1("rst.rv", bus.result_valid, 1'b0);
        chk32("rst.out", bus.fu_out, 32'h0);
        chk1("rst.illegal", bus.illegal_op, 1'b0);
        rst_n = 1'b1;
        tick();

        // Untouched memory reads as zero
        issue("ld_zero", OP_LOAD, 32'h0000_0100, 32'h0000_0024, 1'b0, 32'h0, 32'h0);

        // Basic load after retire write
        retire(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        issue("ld_basic", OP_LOAD, 32'h8, 32'h8, 1'b0, 32'h0, 32'h0);

        // Store address with 32-bit wrap, memory left unchanged
        issue("st_wrap", OP_STORE, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 32'h0);
        issue("ld_after_st", OP_LOAD, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);

        // Same-word dual retire: port 2 wins
        retire(1'b1, 32'h20, 32'h1111, 1'b1, 32'h20, 32'h2222);
        issue("ld_collide", OP_LOAD, 32'h1C, 32'h4, 1'b0, 32'h0, 32'h0);

        // Write-to-read forwarding in the read cycle
        issue("ld_fwd", OP_LOAD, 32'h40, 32'h0, 1'b1, 32'h40, 32'h55AA);

        // Index wrap to word 0 and byte-offset bits ignored
        retire(1'b1, 32'h803, 32'hCAFE_0000, 1'b0, 32'h0, 32'h0);
        issue("ld_wrap", OP_LOAD, 32'h400, 32'h0, 1'b0, 32'h0, 32'h0);

        // Illegal op: zero result, sticky flag
        issue("illegal", 3'd1, 32'h1234, 32'h5678, 1'b0, 32'h0, 32'h0);
        issue("st_sticky", OP_STORE, 32'h100, 32'h20, 1'b0, 32'h0, 32'h0);

        // Reset during the load read cycle; retire write in the reset cycle is dropped
        retire(1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0);
        bus.issue_valid = 1'b1; bus.fu_operation = OP_LOAD; bus.fu_inp1 = 32'h30; bus.fu_inp2 = 32'h0;
        tick();
        bus.issue_valid = 1'b0;
        rst_n = 1'b0;
        bus.we1 = 1'b1; bus.write_address1 = 32'h30; bus.write_data1 = 32'h0BAD_0BAD;
        tick();
        bus.we1 = 1'b0;
        model_illegal = 1'b0;
        chk1("rst_ld.ready", bus.fu_ready, 1'b1);
        chk1("rst_ld.rv", bus.result_valid, 1'b0);
        chk32("rst_ld.out", bus.fu_out, 32'h0);
        chk1("rst_ld.illegal", bus.illegal_op, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("rst_ld.no_pulse", bus.result_valid, 1'b0);
        issue("ld_after_rst", OP_LOAD, 32'h2C, 32'h4, 1'b0, 32'h0, 32'h0);

        // Randomized mix against the reference memory
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            t  = ({28'h0, 4'($urandom_range(0, 15))} << 2) + (32'($urandom_range(0, 3)) << 10)
                 + 32'($urandom_range(0, 3));
            a1 = ({28'h0, 4'($urandom_range(0, 15))} << 2) + (32'($urandom_range(0, 3)) << 10);
            a2 = ({28'h0, 4'($urandom_range(0, 15))} << 2) + (32'($urandom_range(0, 3)) << 10);
            if (kind <= 3) begin
                retire(1'($urandom_range(0, 1)), a1, $urandom, 1'($urandom_range(0, 1)), a2, $urandom);
            end else if (kind <= 6) begin
                a = $urandom;
                issue("rnd_ld", OP_LOAD, a, t - a, 1'($urandom_range(0, 1)), a2, $urandom);
            end else if (kind <= 8) begin
                issue("rnd_st", OP_STORE, $urandom, $urandom, 1'b0, 32'h0, 32'h0);
            end else begin
                issue("rnd_bad", bad_ops[$urandom_range(0, 5)], $urandom, $urandom, 1'b0, 32'h0, 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_fu_responder.md
MEM_FU_RESPONDER -- requirements
Module: mem_fu_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter OP_LOAD, default 3'd5: operation code for a load.
REQ-003 SHALL have parameter OP_STORE, default 3'd6: operation code for a store address-generation.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port issue_valid  input  1  reservation station presents an operation.
REQ-007 SHALL have port fu_operation  input  3  operation code.
REQ-008 SHALL have port fu_inp1  input  32  base operand (rs1 value).
REQ-009 SHALL have port fu_inp2  input  32  offset operand (immediate).
REQ-010 SHALL have port write_address1 / write_data1 / we1  input  32/32/1  retire store port 1 (older instruction).
REQ-011 SHALL have port write_address2 / write_data2 / we2  input  32/32/1  retire store port 2 (younger instruction).
REQ-012 SHALL have port fu_ready  output  1  unit can accept an issue this cycle.
REQ-013 SHALL have port result_valid  output  1  fu_out is valid this cycle (one-cycle pulse).
REQ-014 SHALL have port fu_out  output  32  load data or store effective address.
REQ-015 SHALL have port illegal_op  output  1  sticky: a non-load/store code was accepted.

Function
REQ-016 SHALL implement states IDLE, LD_READ, RESP; fu_ready=1 only in IDLE.
REQ-017 SHALL accept an issue only when issue_valid && fu_ready; an issue_valid while not ready SHALL be ignored with no state change.
REQ-018 SHALL compute the effective address EA = fu_inp1 + fu_inp2 modulo 2^32; word index = EA[31:2] modulo MEM_WORDS; EA[1:0] ignored.
REQ-019 On an accepted OP_STORE: IDLE->RESP; next cycle result_valid=1, fu_out=EA (latency 1); no memory write.
REQ-020 On an accepted OP_LOAD: latch index, IDLE->LD_READ->RESP; in RESP result_valid=1, fu_out=memory word (latency 2).
REQ-021 On an accepted other code: IDLE->RESP, fu_out=0, result_valid=1, illegal_op set and held until reset.
REQ-022 RESP SHALL always return to IDLE next cycle; max throughput is one store per 2 cycles and one load per 3.
REQ-023 Retire writes SHALL be performed in any state, same edge: we1 writes write_data1, we2 writes write_data2, index rule of REQ-018.
REQ-024 If we1 and we2 target the same word in one cycle, port 2 data SHALL be the stored value.
REQ-025 Load read in LD_READ SHALL return memory content including any retire write committed in that same cycle (write-to-read forwarding, port 2 priority over port 1 over array).
REQ-026 fu_out SHALL hold its last value outside RESP; result_valid SHALL be 0 outside RESP.
REQ-027 Memory array SHALL initialise to all zeros at time zero and SHALL NOT be cleared by reset.

Reset
REQ-028 While rst_n=0 at a rising edge: state=IDLE, fu_ready=1, result_valid=0, fu_out=0, illegal_op=0; retire writes in that cycle SHALL be dropped.
REQ-029 Reset asserted in LD_READ or RESP SHALL discard the pending operation with no result_valid pulse after reset release.

Verification
REQ-030 we1=1, addr 0x10, data 0xDEADBEEF; later LOAD inp1=0x8, inp2=0x8 -> fu_ready low 2 cycles, RESP: result_valid=1, fu_out=0xDEADBEEF.
REQ-031 STORE inp1=0xFFFFFFFC, inp2=0x8 -> next cycle result_valid=1, fu_out=0x00000004; memory unchanged.
REQ-032 we1 and we2 both to addr 0x20 with 0x1111/0x2222, then LOAD EA 0x20 -> fu_out=0x2222.
REQ-033 LOAD EA 0x40 issued; in its LD_READ cycle we2 writes 0x40 with 0x55AA -> fu_out=0x55AA; issue_valid held during busy cycles is not accepted twice.
REQ-034 LOAD EA 0x400 with MEM_WORDS=256 -> reads word index 0 (wrap); op 3'd1 -> fu_out=0, illegal_op=1 and stays 1.
REQ-035 Reset pulsed in LD_READ -> next cycle fu_ready=1, result_valid=0, fu_out=0; previously written memory word still readable.
